// File: rtl/alu_pipe_mul_if.sv
// Valid/ready bundle between an execute-stage driver (master) and alu_pipe_mul (slave).
interface alu_pipe_mul_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] InA;
    logic [W-1:0] InB;
    logic         Cin;
    logic [3:0]   Oper;
    logic         invA;
    logic         invB;
    logic         sign;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Out;
    logic         Ofl;
    logic         Zero;
    logic         Cout;
    logic         Neg;
    logic         busy;

    modport master (
        output in_valid, InA, InB, Cin, Oper, invA, invB, sign, out_ready,
        input  in_ready, out_valid, Out, Ofl, Zero, Cout, Neg, busy
    );

    modport slave (
        input  in_valid, InA, InB, Cin, Oper, invA, invB, sign, out_ready,
        output in_ready, out_valid, Out, Ofl, Zero, Cout, Neg, busy
    );
endinterface

// File: rtl/alu_pipe_mul.sv
// Registered ALU with valid/ready handshakes; single-cycle logic/shift/add/compare ops
// and an iterative shift-add multiply that stalls the input while it runs.
module alu_pipe_mul #(
    parameter int OPERAND_WIDTH  = 16,
    parameter int NUM_OPERATIONS = 4
) (
    input logic           clk,
    input logic           rst,
    alu_pipe_mul_if.slave bus
);
    localparam int W   = OPERAND_WIDTH;
    localparam int SHW = $clog2(W);
    localparam int CW  = $clog2(W + 1);
    localparam int W1  = W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [NUM_OPERATIONS-1:0] OP_ROL = 4'b0000;
    localparam logic [NUM_OPERATIONS-1:0] OP_SLL = 4'b0001;
    localparam logic [NUM_OPERATIONS-1:0] OP_ROR = 4'b0010;
    localparam logic [NUM_OPERATIONS-1:0] OP_SRL = 4'b0011;
    localparam logic [NUM_OPERATIONS-1:0] OP_ADD = 4'b0100;
    localparam logic [NUM_OPERATIONS-1:0] OP_AND = 4'b0101;
    localparam logic [NUM_OPERATIONS-1:0] OP_OR  = 4'b0110;
    localparam logic [NUM_OPERATIONS-1:0] OP_XOR = 4'b0111;
    localparam logic [NUM_OPERATIONS-1:0] OP_SEQ = 4'b1000;
    localparam logic [NUM_OPERATIONS-1:0] OP_SLT = 4'b1001;
    localparam logic [NUM_OPERATIONS-1:0] OP_SLE = 4'b1010;
    localparam logic [NUM_OPERATIONS-1:0] OP_MUL = 4'b1011;
    localparam logic [NUM_OPERATIONS-1:0] OP_BTR = 4'b1111;

    logic [1:0]                state_q, state_d;
    logic [CW-1:0]             count_q, count_d;
    logic [2*W-1:0]            mcand_q, mcand_d;
    logic [2*W-1:0]            acc_q, acc_d;
    logic [W-1:0]              mplier_q, mplier_d;
    logic [W-1:0]              out_q, out_d;
    logic                      ofl_q, ofl_d;
    logic                      zero_q, zero_d;
    logic                      cout_q, cout_d;
    logic                      neg_q, neg_d;
    logic                      out_valid_q, out_valid_d;

    logic [NUM_OPERATIONS-1:0] op;
    logic [W-1:0]              a_op, b_op, btr, alu_res;
    logic signed [W-1:0]       sa, sb;
    logic [SHW-1:0]            sh;
    logic [2*W-1:0]            rot_l, rot_r;
    logic [W:0]                add_full;
    logic                      alu_ofl, alu_cout, alu_zero, op_defined;
    logic [2*W-1:0]            mul_sum, prod_fin;
    logic                      out_free, in_ready, accept, alu_load, mul_load;

    assign op   = bus.Oper;
    assign sa   = bus.InA;
    assign sb   = bus.InB;
    assign a_op = bus.invA ? ~bus.InA : bus.InA;
    assign b_op = bus.invB ? ~bus.InB : bus.InB;
    assign sh   = bus.InB[SHW-1:0];

    // Bit reversal always works on the raw operand, regardless of invA.
    for (genvar gi = 0; gi < W; gi++) begin : g_btr
        assign btr[gi] = bus.InA[W-1-gi];
    end

    always_comb begin
        rot_l      = {a_op, a_op} << sh;
        rot_r      = {a_op, a_op} >> sh;
        add_full   = {1'b0, a_op} + {1'b0, b_op} + W1'(bus.Cin);
        alu_res    = '0;
        alu_ofl    = 1'b0;
        alu_cout   = 1'b0;
        op_defined = 1'b1;
        case (op)
            OP_ROL: alu_res = rot_l[2*W-1:W];
            OP_SLL: alu_res = a_op << sh;
            OP_ROR: alu_res = rot_r[W-1:0];
            OP_SRL: alu_res = a_op >> sh;
            OP_ADD: begin
                alu_res  = add_full[W-1:0];
                alu_cout = add_full[W];
                alu_ofl  = bus.sign ? ((a_op[W-1] == b_op[W-1]) && (add_full[W-1] != a_op[W-1]))
                                    : add_full[W];
            end
            OP_AND: alu_res = a_op & b_op;
            OP_OR:  alu_res = a_op | b_op;
            OP_XOR: alu_res = a_op ^ b_op;
            OP_SEQ: alu_res = {{(W-1){1'b0}}, sa == sb};
            OP_SLT: alu_res = {{(W-1){1'b0}}, sa < sb};
            OP_SLE: alu_res = {{(W-1){1'b0}}, sa <= sb};
            OP_BTR: alu_res = btr;
            OP_MUL: alu_res = '0;
            default: op_defined = 1'b0;
        endcase
        // Reserved opcodes report all flags low, including Zero.
        alu_zero = op_defined && (alu_res == '0);
    end

    assign out_free = !out_valid_q || bus.out_ready;
    assign in_ready = !rst && (state_q == S_IDLE) && out_free;
    assign accept   = bus.in_valid && in_ready;
    assign alu_load = accept && (op != OP_MUL);
    assign mul_load = out_free && (((state_q == S_MUL) && (count_q == CW'(1))) || (state_q == S_HOLD));
    assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_fin = (state_q == S_HOLD) ? acc_q : mul_sum;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            S_IDLE: begin
                if (accept && (op == OP_MUL)) begin
                    state_d  = S_MUL;
                    mcand_d  = {{W{1'b0}}, a_op};
                    mplier_d = b_op;
                    acc_d    = '0;
                    count_d  = CW'(W);
                end
            end
            S_MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = out_free ? S_IDLE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_free) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_d       = out_q;
        ofl_d       = ofl_q;
        zero_d      = zero_q;
        cout_d      = cout_q;
        neg_d       = neg_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        if (alu_load) begin
            out_d       = alu_res;
            ofl_d       = alu_ofl;
            zero_d      = alu_zero;
            cout_d      = alu_cout;
            neg_d       = alu_res[W-1];
            out_valid_d = 1'b1;
        end else if (mul_load) begin
            out_d       = prod_fin[W-1:0];
            ofl_d       = |prod_fin[2*W-1:W];
            zero_d      = (prod_fin[W-1:0] == '0);
            cout_d      = 1'b0;
            neg_d       = prod_fin[W-1];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            ofl_q       <= 1'b0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            ofl_q       <= ofl_d;
            zero_q      <= zero_d;
            cout_q      <= cout_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.Out       = out_q;
    assign bus.Ofl       = ofl_q;
    assign bus.Zero      = zero_q;
    assign bus.Cout      = cout_q;
    assign bus.Neg       = neg_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_pipe_mul.sv
// Directed W=16 checks plus randomised W=8/16/32 runs scored against an arithmetic model.
module tb_alu_pipe_mul;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   rand_done [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_mul_if #(.W(16)) dif ();
    alu_pipe_mul #(.OPERAND_WIDTH(16), .NUM_OPERATIONS(4)) u_dut (.clk(clk), .rst(rst), .bus(dif));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint to_signed(input int w, input longint unsigned v);
        if (((v >> (w - 1)) & 64'd1) != 64'd0) return longint'(v) - longint'(64'd1 << w);
        return longint'(v);
    endfunction

    // Result packed as {Out, Ofl, Zero, Cout, Neg}.
    function automatic logic [63:0] model(input int w, input longint unsigned ia, input longint unsigned ib,
                                          input logic cin, input logic [3:0] op,
                                          input logic ia_inv, input logic ib_inv, input logic sgn);
        longint unsigned mask, a, b, r, s;
        longint ss, lim;
        int sh;
        logic ofl, cout, defined, zero, neg;
        mask = (64'd1 << w) - 64'd1;
        a = (ia_inv ? ~ia : ia) & mask;
        b = (ib_inv ? ~ib : ib) & mask;
        sh = int'(ib % 64'(w));
        lim = longint'(64'd1 << (w - 1));
        r = 0; ofl = 1'b0; cout = 1'b0; defined = 1'b1;
        case (op)
            4'd0: r = ((a << sh) | (a >> (w - sh))) & mask;
            4'd1: r = (a << sh) & mask;
            4'd2: r = ((a >> sh) | (a << (w - sh))) & mask;
            4'd3: r = a >> sh;
            4'd4: begin
                s = a + b + 64'(cin);
                r = s & mask;
                cout = ((s >> w) & 64'd1) != 0;
                ss = to_signed(w, a) + to_signed(w, b) + longint'(cin);
                ofl = sgn ? (ss >= lim || ss < -lim) : cout;
            end
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8: r = 64'(to_signed(w, ia) == to_signed(w, ib));
            4'd9: r = 64'(to_signed(w, ia) < to_signed(w, ib));
            4'd10: r = 64'(to_signed(w, ia) <= to_signed(w, ib));
            4'd11: begin
                s = a * b;
                r = s & mask;
                ofl = (s >> w) != 0;
            end
            4'd15: for (int i = 0; i < w; i++) if (((ia >> i) & 64'd1) != 0) r = r | (64'd1 << (w - 1 - i));
            default: defined = 1'b0;
        endcase
        zero = defined && (r == 0);
        neg = ((r >> (w - 1)) & 64'd1) != 0;
        return (r << 4) | 64'({ofl, zero, cout, neg});
    endfunction

    function automatic longint unsigned pick(input int w);
        case ($urandom_range(0, 5))
            0: return 0;
            1: return (64'd1 << w) - 64'd1;
            2: return 64'd1 << (w - 1);
            default: return {$urandom, $urandom} & ((64'd1 << w) - 64'd1);
        endcase
    endfunction

    function automatic logic [63:0] obs16();
        return {44'd0, dif.Out, dif.Ofl, dif.Zero, dif.Cout, dif.Neg};
    endfunction

    task automatic drive16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic inva, input logic sg);
        dif.Oper = op; dif.InA = a; dif.InB = b; dif.Cin = 1'b0;
        dif.invA = inva; dif.invB = 1'b0; dif.sign = sg; dif.in_valid = 1'b1;
    endtask

    task automatic run_single(input string tag, input logic [3:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic inva, input logic sg,
                              input logic [63:0] exp);
        @(posedge clk); #1;
        dif.out_ready = 1'b1;
        drive16(op, a, b, inva, sg);
        @(negedge clk);
        check({tag, "_rdy"}, 64'(dif.in_ready), 64'd1);
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        check({tag, "_vld"}, 64'(dif.out_valid), 64'd1);
        check(tag, obs16(), exp);
        $display("txn %s out=%h ofl=%b zero=%b cout=%b neg=%b", tag, dif.Out, dif.Ofl, dif.Zero, dif.Cout, dif.Neg);
    endtask

    initial begin : p_directed
        int lat, bad, pi, seen;
        logic [15:0] got [$];
        logic [15:0] bp_a [3];
        logic [15:0] bp_b [3];
        logic [3:0]  bp_op [3];
        checks = 0; errors = 0;
        rst = 1'b1;
        dif.in_valid = 1'b0; dif.out_ready = 1'b1; dif.InA = '0; dif.InB = '0; dif.Cin = 1'b0;
        dif.Oper = '0; dif.invA = 1'b0; dif.invB = 1'b0; dif.sign = 1'b0;
        @(negedge clk);
        check("rst_obs", obs16(), 64'd0);
        check("rst_ctl", 64'({dif.out_valid, dif.busy, dif.in_ready}), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", 64'(dif.in_ready), 64'd1);

        run_single("add_s_ovf", 4'b0100, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 64'h80009);
        run_single("add_u_wrap", 4'b0100, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 64'h0000E);
        run_single("rol", 4'b0000, 16'h8001, 16'h0004, 1'b0, 1'b0, 64'h00180);
        run_single("srl", 4'b0011, 16'h8000, 16'h000F, 1'b0, 1'b0, 64'h00010);
        run_single("btr_inv", 4'b1111, 16'h0001, 16'h0000, 1'b1, 1'b0, 64'h80001);
        run_single("slt", 4'b1001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 64'h00010);

        // Multiply latency: out_valid must rise on the 16th edge after accept.
        @(posedge clk); #1;
        drive16(4'b1011, 16'h0100, 16'h0100, 1'b0, 1'b0);
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        lat = -1; bad = 0;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            if (dif.out_valid) lat = k;
            else begin
                if (!dif.busy || dif.in_ready) bad++;
                @(posedge clk); #1;
            end
        end
        check("mul_lat", 64'(lat), 64'd16);
        check("mul_busy", 64'(bad), 64'd0);
        check("mul_res", obs16(), 64'h0000C);
        check("mul_idle", 64'(dif.busy), 64'd0);
        $display("txn mul out=%h lat=%0d", dif.Out, lat);

        // Back-pressure: three ops offered while the consumer stalls for five cycles.
        bp_op[0] = 4'b0100; bp_a[0] = 16'h0001; bp_b[0] = 16'h0002;
        bp_op[1] = 4'b0111; bp_a[1] = 16'h00FF; bp_b[1] = 16'h0F0F;
        bp_op[2] = 4'b0110; bp_a[2] = 16'h1000; bp_b[2] = 16'h0001;
        pi = 0; bad = 0;
        for (int t = 0; t < 30 && got.size() < 3; t++) begin
            @(posedge clk); #1;
            dif.out_ready = (t >= 5);
            if (pi < 3) drive16(bp_op[pi], bp_a[pi], bp_b[pi], 1'b0, 1'b0);
            else dif.in_valid = 1'b0;
            @(negedge clk);
            if (t >= 1 && t < 5 && (dif.in_ready || !dif.out_valid || dif.Out !== 16'h0003)) bad++;
            if (dif.out_valid && dif.out_ready) got.push_back(dif.Out);
            if (dif.in_valid && dif.in_ready) pi++;
        end
        @(posedge clk); #1; dif.in_valid = 1'b0;
        check("bp_hold", 64'(bad), 64'd0);
        check("bp_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            check("bp_r0", 64'(got[0]), 64'h0003);
            check("bp_r1", 64'(got[1]), 64'h0FF0);
            check("bp_r2", 64'(got[2]), 64'h1001);
            $display("txn bp results %h %h %h", got[0], got[1], got[2]);
        end

        // Reset five cycles into a multiply: outputs clear at once, nothing emerges later.
        @(posedge clk); #1;
        drive16(4'b1011, 16'h00FF, 16'h0003, 1'b0, 1'b0);
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midmul_rst_obs", obs16(), 64'd0);
        check("midmul_rst_ctl", 64'({dif.out_valid, dif.busy, dif.in_ready}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (dif.out_valid || dif.busy) seen++;
        end
        check("midmul_no_result", 64'(seen), 64'd0);
        $display("txn midmul_rst seen=%0d", seen);
        run_single("post_rst_add", 4'b0100, 16'h0005, 16'h0003, 1'b0, 1'b0, 64'h00080);

        for (int t = 0; t < 8000 && !(rand_done[0] && rand_done[1] && rand_done[2]); t++) @(posedge clk);
        check("rand_done", 64'({rand_done[0], rand_done[1], rand_done[2]}), 64'h7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_rand
        localparam int GW = (gi == 0) ? 8 : ((gi == 1) ? 16 : 32);
        logic rst_g;
        alu_pipe_mul_if #(.W(GW)) rif ();
        alu_pipe_mul #(.OPERAND_WIDTH(GW), .NUM_OPERATIONS(4)) u_dut (.clk(clk), .rst(rst_g), .bus(rif));

        initial begin : p_rand
            logic [63:0] exp_q [$];
            logic [63:0] prev_obs, obs, e;
            logic        prev_hold;
            rand_done[gi] = 1'b0;
            rst_g = 1'b1;
            rif.in_valid = 1'b0; rif.out_ready = 1'b0; rif.InA = '0; rif.InB = '0; rif.Cin = 1'b0;
            rif.Oper = '0; rif.invA = 1'b0; rif.invB = 1'b0; rif.sign = 1'b0;
            prev_hold = 1'b0; prev_obs = '0;
            repeat (3) @(posedge clk);
            #1 rst_g = 1'b0;
            for (int cyc = 0; cyc < 2500; cyc++) begin
                @(posedge clk); #1;
                rif.in_valid  = (cyc < 2350) && ($urandom_range(0, 3) != 0);
                rif.Oper      = 4'($urandom_range(0, 15));
                rif.InA       = GW'(pick(GW));
                rif.InB       = GW'(pick(GW));
                rif.Cin       = 1'($urandom);
                rif.invA      = 1'($urandom);
                rif.invB      = (rif.Oper < 4'd4) ? 1'b0 : 1'($urandom);
                rif.sign      = 1'($urandom);
                rif.out_ready = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                obs = 64'({rif.Out, rif.Ofl, rif.Zero, rif.Cout, rif.Neg});
                if (prev_hold) begin
                    check($sformatf("w%0d_hold", GW), obs, prev_obs);
                    check($sformatf("w%0d_hold_vld", GW), 64'(rif.out_valid), 64'd1);
                end
                if (rif.out_valid && rif.out_ready) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                    check($sformatf("w%0d_res", GW), obs, e);
                    $display("w%0d txn out=%h flags=%b", GW, rif.Out, {rif.Ofl, rif.Zero, rif.Cout, rif.Neg});
                end
                prev_hold = rif.out_valid && !rif.out_ready;
                prev_obs  = obs;
                if (rif.in_valid && rif.in_ready)
                    exp_q.push_back(model(GW, 64'(rif.InA), 64'(rif.InB), rif.Cin, rif.Oper,
                                          rif.invA, rif.invB, rif.sign));
            end
            check($sformatf("w%0d_drain", GW), 64'(exp_q.size()), 64'd0);
            rand_done[gi] = 1'b1;
        end
    end
endmodule
